mem_wrapper_responder: RTL and testbench

- Clocked memory-side responder for the wrapper's memory command interface (read, write, timestep T, x, y, data in, data out).
- Accepts one command at a time through a valid/ready request handshake.
- Stores data words in a flat array indexed by (t, y, x).
- Returns read data through a valid/ready response handshake, so the memory wrapper and NoC tester can use a synchronous memory model.

---
 rtl/mem_wrapper_responder_if.sv | 34 +++
 rtl/mem_wrapper_responder.sv | 118 +++++++++++
 tb/tb_mem_wrapper_responder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_wrapper_responder_if.sv
// rtl/mem_wrapper_responder_if.sv - request/response/status bundle between memory wrapper and responder
interface mem_wrapper_responder_if #(
    parameter int DATA_W = 8,
    parameter int X_W    = 3,
    parameter int Y_W    = 3,
    parameter int T_W    = 1,
    parameter int CNT_W  = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_read;
    logic              req_write;
    logic [T_W-1:0]    req_t;
    logic [X_W-1:0]    req_x;
    logic [Y_W-1:0]    req_y;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              err_flag;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;

    modport master (
        output req_valid, req_read, req_write, req_t, req_x, req_y, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err, err_flag, rd_cnt, wr_cnt
    );

    modport slave (
        input  req_valid, req_read, req_write, req_t, req_x, req_y, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err, err_flag, rd_cnt, wr_cnt
    );
endinterface

// File: rtl/mem_wrapper_responder.sv
// rtl/mem_wrapper_responder.sv - synchronous (t,y,x)-addressed memory model with request/response handshakes
module mem_wrapper_responder #(
    parameter int DATA_W = 8,
    parameter int X_DIM  = 5,
    parameter int Y_DIM  = 5,
    parameter int T_DIM  = 2,
    parameter int X_W    = 3,
    parameter int Y_W    = 3,
    parameter int T_W    = 1,
    parameter int CNT_W  = 16
) (
    input  logic clk,
    input  logic reset,
    mem_wrapper_responder_if.slave bus
);
    localparam int DEPTH = T_DIM * X_DIM * Y_DIM;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     lat_addr;
    logic              lat_inr;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic              err_flag_q;
    logic [CNT_W-1:0]  rd_cnt_q;
    logic [CNT_W-1:0]  wr_cnt_q;

    logic              in_range;
    logic [AW-1:0]     addr;
    logic              accept;
    logic              mem_we;

    // Range check on full input widths (no wrap), and the flat address it guards
    always_comb begin
        in_range = (32'(bus.req_t) < 32'(T_DIM)) &&
                   (32'(bus.req_y) < 32'(Y_DIM)) &&
                   (32'(bus.req_x) < 32'(X_DIM));
        addr     = (AW'(bus.req_t) * AW'(Y_DIM) + AW'(bus.req_y)) * AW'(X_DIM) + AW'(bus.req_x);
        accept   = (state == IDLE) && bus.req_valid;
        mem_we   = accept && bus.req_write && !bus.req_read && in_range;
    end

    assign bus.req_ready = (state == IDLE) && !reset;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.err_flag  = err_flag_q;
    assign bus.rd_cnt    = rd_cnt_q;
    assign bus.wr_cnt    = wr_cnt_q;

    // Storage array: not reset, so contents survive a mid-operation reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= bus.req_data;
        end
    end

    // Command FSM: accept in IDLE, fetch in READ, hold the response in RESP until taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lat_addr   <= '0;
            lat_inr    <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            err_flag_q <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        unique case ({bus.req_read, bus.req_write})
                            2'b01: begin
                                if (in_range) begin
                                    wr_cnt_q <= wr_cnt_q + 1'b1;
                                end else begin
                                    err_flag_q <= 1'b1;
                                end
                            end
                            2'b10: begin
                                lat_addr <= addr;
                                lat_inr  <= in_range;
                                state    <= READ;
                            end
                            2'b11: begin
                                // Ambiguous command: flag it, touch nothing
                                err_flag_q <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                READ: begin
                    rsp_data_q <= lat_inr ? mem[lat_addr] : '0;
                    rsp_err_q  <= !lat_inr;
                    if (!lat_inr) begin
                        err_flag_q <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_wrapper_responder.sv
// tb/tb_mem_wrapper_responder.sv - directed self-checking bench for mem_wrapper_responder
module tb_mem_wrapper_responder;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   exp_wr;
    int   exp_rd;
    logic exp_err;

    mem_wrapper_responder_if #(.DATA_W(8), .X_W(3), .Y_W(3), .T_W(1), .CNT_W(4)) bus ();

    mem_wrapper_responder #(
        .DATA_W(8), .X_DIM(5), .Y_DIM(5), .T_DIM(2),
        .X_W(3), .Y_W(3), .T_W(1), .CNT_W(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int t, input int x, input int y, input logic [7:0] d);
        bus.req_valid = 1'b1;
        bus.req_read  = 1'b0;
        bus.req_write = 1'b1;
        bus.req_t     = t[0];
        bus.req_x     = x[2:0];
        bus.req_y     = y[2:0];
        bus.req_data  = d;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        if (t < 2 && x < 5 && y < 5) exp_wr = (exp_wr + 1) % 16;
        else exp_err = 1'b1;
        check("wr_cnt", {28'd0, bus.wr_cnt}, exp_wr);
        check("wr_ready", {31'd0, bus.req_ready}, 1);
        check("wr_err_flag", {31'd0, bus.err_flag}, {31'd0, exp_err});
    endtask

    task automatic rd(input int t, input int x, input int y, input int stall,
                      input logic [7:0] exp_d, input logic exp_e, input string tag);
        bus.req_valid = 1'b1;
        bus.req_read  = 1'b1;
        bus.req_write = 1'b0;
        bus.req_t     = t[0];
        bus.req_x     = x[2:0];
        bus.req_y     = y[2:0];
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_read  = 1'b0;
        check({tag, "_busy_ready"}, {31'd0, bus.req_ready}, 0);
        check({tag, "_early_valid"}, {31'd0, bus.rsp_valid}, 0);
        @(negedge clk);
        check({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 1);
        check({tag, "_rsp_data"}, {24'd0, bus.rsp_data}, {24'd0, exp_d});
        check({tag, "_rsp_err"}, {31'd0, bus.rsp_err}, {31'd0, exp_e});
        for (int s = 0; s < stall; s++) begin
            bus.req_valid = 1'b1;
            bus.req_write = 1'b1;
            bus.req_t     = 1'b0;
            bus.req_x     = 3'd0;
            bus.req_y     = 3'd0;
            bus.req_data  = 8'hEE;
            check({tag, "_stall_valid"}, {31'd0, bus.rsp_valid}, 1);
            check({tag, "_stall_data"}, {24'd0, bus.rsp_data}, {24'd0, exp_d});
            check({tag, "_stall_ready"}, {31'd0, bus.req_ready}, 0);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        exp_rd = (exp_rd + 1) % 16;
        if (exp_e) exp_err = 1'b1;
        check({tag, "_done_valid"}, {31'd0, bus.rsp_valid}, 0);
        check({tag, "_done_ready"}, {31'd0, bus.req_ready}, 1);
        check({tag, "_rd_cnt"}, {28'd0, bus.rd_cnt}, exp_rd);
        check({tag, "_wr_cnt"}, {28'd0, bus.wr_cnt}, exp_wr);
        check({tag, "_err_flag"}, {31'd0, bus.err_flag}, {31'd0, exp_err});
    endtask

    initial begin
        checks = 0; failures = 0;
        exp_wr = 0; exp_rd = 0; exp_err = 1'b0;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_read = 1'b0; bus.req_write = 1'b0;
        bus.req_t = '0; bus.req_x = '0; bus.req_y = '0; bus.req_data = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_ready_low", {31'd0, bus.req_ready}, 0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
        reset = 1'b0;
        #1;
        check("rst_ready_high", {31'd0, bus.req_ready}, 1);
        check("rst_rsp_data", {24'd0, bus.rsp_data}, 0);
        check("rst_rsp_err", {31'd0, bus.rsp_err}, 0);
        check("rst_err_flag", {31'd0, bus.err_flag}, 0);
        check("rst_rd_cnt", {28'd0, bus.rd_cnt}, 0);
        check("rst_wr_cnt", {28'd0, bus.wr_cnt}, 0);
        @(negedge clk);

        // Write-then-read at the far corner (addr 49)
        wr(1, 4, 4, 8'hA5);
        rd(1, 4, 4, 0, 8'hA5, 1'b0, "corner");

        // Back-to-back writes, then read them back in order
        wr(0, 0, 0, 8'h11);
        wr(0, 1, 0, 8'h22);
        wr(0, 2, 0, 8'h33);
        rd(0, 0, 0, 0, 8'h11, 1'b0, "b2b0");
        rd(0, 1, 0, 0, 8'h22, 1'b0, "b2b1");
        rd(0, 2, 0, 0, 8'h33, 1'b0, "b2b2");

        // Read-after-write on the very next cycle
        wr(0, 3, 3, 8'h5C);
        rd(0, 3, 3, 0, 8'h5C, 1'b0, "raw");

        // Out-of-range write x=5 must not alias onto (x=0,y=1)
        wr(0, 0, 1, 8'h66);
        wr(0, 5, 0, 8'hFF);
        rd(0, 0, 1, 0, 8'h66, 1'b0, "no_alias");

        // Out-of-range read y=7
        rd(0, 0, 7, 0, 8'h00, 1'b1, "oor_y");

        // Response backpressure, with ignored request activity during the stall
        rd(0, 0, 0, 5, 8'h11, 1'b0, "stall");

        // Reset while a response is pending
        bus.req_valid = 1'b1; bus.req_read = 1'b1; bus.req_write = 1'b0;
        bus.req_t = 1'b1; bus.req_x = 3'd4; bus.req_y = 3'd4;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_read = 1'b0;
        @(negedge clk);
        check("mid_rsp_valid", {31'd0, bus.rsp_valid}, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_valid_drop", {31'd0, bus.rsp_valid}, 0);
        check("mid_ready_low", {31'd0, bus.req_ready}, 0);
        check("mid_rd_cnt", {28'd0, bus.rd_cnt}, 0);
        check("mid_wr_cnt", {28'd0, bus.wr_cnt}, 0);
        check("mid_err_flag", {31'd0, bus.err_flag}, 0);
        check("mid_rsp_data", {24'd0, bus.rsp_data}, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_rd = 0; exp_wr = 0; exp_err = 1'b0;
        #1;
        check("mid_ready_back", {31'd0, bus.req_ready}, 1);
        @(negedge clk);

        // Read and write both set: error, no access, no response
        bus.req_valid = 1'b1; bus.req_read = 1'b1; bus.req_write = 1'b1;
        bus.req_t = 1'b0; bus.req_x = 3'd0; bus.req_y = 3'd0; bus.req_data = 8'h99;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_read = 1'b0; bus.req_write = 1'b0;
        exp_err = 1'b1;
        check("rw_ready", {31'd0, bus.req_ready}, 1);
        check("rw_no_rsp", {31'd0, bus.rsp_valid}, 0);
        check("rw_err_flag", {31'd0, bus.err_flag}, 1);
        check("rw_wr_cnt", {28'd0, bus.wr_cnt}, 0);
        @(negedge clk);
        check("rw_no_rsp_later", {31'd0, bus.rsp_valid}, 0);

        // Array retained across reset; rd+wr left addr 0 alone
        rd(1, 4, 4, 0, 8'hA5, 1'b0, "retain49");
        rd(0, 0, 0, 0, 8'h11, 1'b0, "retain0");

        // 17 writes wrap the 4-bit write counter to 1
        for (int i = 0; i < 17; i++) begin
            wr(0, i % 5, i / 5, 8'(i + 8'h40));
        end
        check("wrap_wr_cnt", {28'd0, bus.wr_cnt}, 1);
        rd(0, 1, 3, 0, 8'h50, 1'b0, "wrap_data");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
